// File: rtl/ahb_defs.sv
// Shared AHB encodings and bridge FSM state codes.
package ahb_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RESP   = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_t;

  // NONSEQ and SEQ both have bit 1 set; IDLE/BUSY carry no transfer.
  function automatic logic is_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_size_decoder.sv
// Size/alignment check and byte-strobe generation for one AHB address phase.
module ahb_size_decoder
  import ahb_defs::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] size,
  input  logic       write,
  output logic       legal,
  output logic [3:0] wstrb
);

  // Decode lane strobes; reads and illegal transfers get no strobes.
  always_comb begin
    legal = 1'b0;
    wstrb = 4'b0000;
    case (size)
      HSIZE_BYTE: begin
        legal = 1'b1;
        wstrb = 4'b0001 << addr_lo;
      end
      HSIZE_HALF: begin
        legal = ~addr_lo[0];
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      end
      HSIZE_WORD: begin
        legal = (addr_lo == 2'b00);
        wstrb = 4'b1111;
      end
      default: begin
        legal = 1'b0;
        wstrb = 4'b0000;
      end
    endcase
    if (!write || !legal) wstrb = 4'b0000;
  end

endmodule

// File: rtl/ahb_to_native_mem_slave.sv
// AHB-Lite slave bridging to a valid/ready native memory port.
module ahb_to_native_mem_slave
  import ahb_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] HRDATA_IDLE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     addr_q;
  logic [3:0]      wstrb_q;
  logic            instr_q;
  logic            write_q;
  logic [31:0]     hrdata_q;

  logic            dec_legal;
  logic [3:0]      dec_wstrb;
  logic            take;
  logic            can_take;
  logic            timeout_hit;

  logic unused_ok;
  assign unused_ok = ^{hprot[3:1], htrans[0]};

  ahb_size_decoder u_dec (
    .addr_lo (haddr[1:0]),
    .size    (hsize),
    .write   (hwrite),
    .legal   (dec_legal),
    .wstrb   (dec_wstrb)
  );

  // Address phases are only taken when no data phase is stalling the bus.
  assign can_take    = (state_q == ST_IDLE) || (state_q == ST_RESP) || (state_q == ST_ERR2);
  assign take        = can_take && hsel && hready && is_active(htrans);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    mem_valid = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP, ST_ERR2: begin
        hresp = (state_q == ST_ERR2);
        if (take) state_d = dec_legal ? ST_ACCESS : ST_ERR1;
        else      state_d = ST_IDLE;
      end
      ST_ACCESS: begin
        hreadyout = 1'b0;
        mem_valid = 1'b1;
        if (mem_ready)        state_d = ST_RESP;
        else if (timeout_hit) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Wait-state counter, restarted each time ACCESS is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                           cnt_q <= '0;
    else if (state_d == ST_ACCESS && state_q != ST_ACCESS) cnt_q <= '0;
    else if (state_q == ST_ACCESS)                       cnt_q <= cnt_q + 1'b1;
  end

  // Capture address-phase attributes and returned read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wstrb_q  <= '0;
      instr_q  <= 1'b0;
      write_q  <= 1'b0;
      hrdata_q <= HRDATA_IDLE;
    end else begin
      if (take) begin
        addr_q  <= {haddr[31:2], 2'b00};
        wstrb_q <= dec_wstrb;
        instr_q <= ~hprot[0];
        write_q <= hwrite;
      end
      if (state_q == ST_ACCESS && mem_ready && !write_q) hrdata_q <= mem_rdata;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_instr = instr_q;
  assign mem_wdata = hwdata;   // master holds hwdata through wait states
  assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_to_native_mem_slave.sv
// Randomised self-checking bench for the AHB to native memory bridge.
module tb_ahb_to_native_mem_slave;

  localparam logic [31:0] IDLE_DATA = 32'hCAFE_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_hrdata;

  always #5 clk = ~clk;

  ahb_to_native_mem_slave #(.TIMEOUT_CYCLES(4), .HRDATA_IDLE(IDLE_DATA)) dut (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .mem_valid(mem_valid),
    .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                            input logic [3:0] prot);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; hprot = prot;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  // One transfer checked against a byte-lane model of the bus rules.
  task automatic do_xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [3:0] prot, input logic [31:0] wd, input int lat,
                         input logic [31:0] rd);
    int nbytes;
    int lo;
    logic legal;
    logic [3:0] estrb;
    nbytes = 1 << sz;
    lo     = int'(a[1:0]);
    legal  = (sz <= 3'd2) && ((lo % nbytes) == 0);
    estrb  = 4'b0000;
    if (w && legal)
      for (int i = 0; i < 4; i++) if (i >= lo && i < lo + nbytes) estrb[i] = 1'b1;
    addr_phase(a, w, sz, prot);
    step();
    bus_idle();
    hwdata = wd;
    #1;
    if (!legal) begin
      n_checks++;
      if ({mem_valid, hreadyout, hresp} !== 3'b001)
        $display("FAIL err1 a=%h sz=%0d: valid/rdy/resp=%b want 001", a, sz, {mem_valid, hreadyout, hresp});
      else n_pass++;
      step();
      n_checks++;
      if ({mem_valid, hreadyout, hresp} !== 3'b011)
        $display("FAIL err2 a=%h: valid/rdy/resp=%b want 011", a, {mem_valid, hreadyout, hresp});
      else n_pass++;
    end else begin
      n_checks++;
      if ({mem_valid, hreadyout, hresp} !== 3'b100)
        $display("FAIL access a=%h: valid/rdy/resp=%b want 100", a, {mem_valid, hreadyout, hresp});
      else n_pass++;
      n_checks++;
      if ({mem_addr, mem_wstrb, mem_instr} !== {a[31:2], 2'b00, estrb, ~prot[0]})
        $display("FAIL req a=%h: addr=%h strb=%b instr=%b want %h %b %b",
                 a, mem_addr, mem_wstrb, mem_instr, {a[31:2], 2'b00}, estrb, ~prot[0]);
      else n_pass++;
      if (w) begin
        n_checks++;
        if (mem_wdata !== wd) $display("FAIL wdata: got %h want %h", mem_wdata, wd);
        else n_pass++;
      end
      for (int k = 0; k < lat; k++) begin
        step();
        n_checks++;
        if ({mem_valid, hreadyout} !== 2'b10)
          $display("FAIL wait%0d: valid/rdy=%b want 10", k, {mem_valid, hreadyout});
        else n_pass++;
      end
      mem_ready = 1'b1;
      mem_rdata = rd;
      step();
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (!w) exp_hrdata = rd;
      n_checks++;
      if ({mem_valid, hreadyout, hresp} !== 3'b010)
        $display("FAIL resp a=%h: valid/rdy/resp=%b want 010", a, {mem_valid, hreadyout, hresp});
      else n_pass++;
      n_checks++;
      if (hrdata !== exp_hrdata) $display("FAIL hrdata: got %h want %h", hrdata, exp_hrdata);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus_idle(); hready = 1'b1; haddr = '0; hwrite = 1'b0;
    hsize = '0; hprot = '0; hwdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    exp_hrdata = IDLE_DATA;
    step(); step();
    n_checks++;
    if ({mem_valid, hreadyout, hresp, mem_wstrb, mem_addr} !== {3'b010, 4'b0, 32'h0})
      $display("FAIL reset_ctrl: valid/rdy/resp=%b strb=%b addr=%h want 010 0000 0",
               {mem_valid, hreadyout, hresp}, mem_wstrb, mem_addr);
    else n_pass++;
    n_checks++;
    if (hrdata !== IDLE_DATA) $display("FAIL reset_hrdata: got %h want %h", hrdata, IDLE_DATA);
    else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_word_read();
    do_xfer(32'h0000_0100, 1'b0, 3'd2, 4'b0001, 32'h0, 3, 32'hDEAD_BEEF);
  endtask

  task automatic test_byte_write();
    do_xfer(32'h0000_0203, 1'b1, 3'd0, 4'b0011, 32'hAB00_0000, 1, 32'h1234_5678);
  endtask

  task automatic test_misaligned();
    do_xfer(32'h0000_0002, 1'b0, 3'd2, 4'b0001, 32'h0, 0, 32'h0);
    step();
    n_checks++;
    if ({mem_valid, hreadyout, hresp} !== 3'b010)
      $display("FAIL err_exit: valid/rdy/resp=%b want 010", {mem_valid, hreadyout, hresp});
    else n_pass++;
  endtask

  task automatic test_timeout();
    addr_phase(32'h0000_0400, 1'b0, 3'd2, 4'b0001);
    step();
    bus_idle();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({mem_valid, hreadyout, hresp} !== 3'b100)
        $display("FAIL to_valid%0d: valid/rdy/resp=%b want 100", k, {mem_valid, hreadyout, hresp});
      else n_pass++;
      step();
    end
    n_checks++;
    if ({mem_valid, hreadyout, hresp} !== 3'b001)
      $display("FAIL to_err1: valid/rdy/resp=%b want 001", {mem_valid, hreadyout, hresp});
    else n_pass++;
    step();
    n_checks++;
    if ({mem_valid, hreadyout, hresp} !== 3'b011)
      $display("FAIL to_err2: valid/rdy/resp=%b want 011", {mem_valid, hreadyout, hresp});
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    addr_phase(32'h0000_0040, 1'b0, 3'd2, 4'b0001);
    step();
    bus_idle();
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ready = 1'b0;
    exp_hrdata = 32'h0BAD_F00D;
    n_checks++;
    if ({hreadyout, hrdata} !== {1'b1, exp_hrdata})
      $display("FAIL b2b_resp: rdy=%b hrdata=%h want 1 %h", hreadyout, hrdata, exp_hrdata);
    else n_pass++;
    addr_phase(32'h0000_0044, 1'b1, 3'd2, 4'b0000);
    step();
    bus_idle();
    hwdata = 32'h5566_7788;
    #1;
    n_checks++;
    if ({mem_valid, hreadyout, mem_addr, mem_wstrb, mem_instr} !== {2'b10, 32'h44, 4'hF, 1'b1})
      $display("FAIL b2b_access: valid/rdy=%b addr=%h strb=%b instr=%b want 10 00000044 1111 1",
               {mem_valid, hreadyout}, mem_addr, mem_wstrb, mem_instr);
    else n_pass++;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    n_checks++;
    if ({hreadyout, hresp, hrdata} !== {2'b10, exp_hrdata})
      $display("FAIL b2b_done: rdy/resp=%b hrdata=%h want 10 %h", {hreadyout, hresp}, hrdata, exp_hrdata);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_access();
    addr_phase(32'h0000_0080, 1'b1, 3'd1, 4'b0001);
    step();
    bus_idle();
    n_checks++;
    if (mem_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", mem_valid);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    exp_hrdata = IDLE_DATA;
    n_checks++;
    if ({mem_valid, hreadyout, hresp, mem_wstrb, mem_addr, hrdata} !== {3'b010, 4'b0, 32'h0, IDLE_DATA})
      $display("FAIL mid_reset: valid/rdy/resp=%b strb=%b addr=%h hrdata=%h",
               {mem_valid, hreadyout, hresp}, mem_wstrb, mem_addr, hrdata);
    else n_pass++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [2:0] sz;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        mem_ready = 1'b1; mem_rdata = $urandom;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if ({mem_valid, hreadyout, hresp, hrdata} !== {3'b010, exp_hrdata})
          $display("FAIL stray_ready: valid/rdy/resp=%b hrdata=%h want 010 %h",
                   {mem_valid, hreadyout, hresp}, hrdata, exp_hrdata);
        else n_pass++;
      end
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      do_xfer($urandom, 1'($urandom), sz, 4'($urandom), $urandom, $urandom_range(0, 3), $urandom);
    end
    bus_idle();
    step();
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
